// File: rtl/if_stage_pkg.sv
// Shared CPU constants for the fetch stage: data width, the NOP word and the
// fetch FSM encoding.
package if_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

    localparam logic [1:0] ST_FETCH   = 2'd0;
    localparam logic [1:0] ST_BLOCKED = 2'd1;
    localparam logic [1:0] ST_DROP    = 2'd2;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] instr;
    } ifid_t;

endpackage

// File: rtl/if_stage_adder.sv
// Plain XLEN-bit adder, wrapping modulo 2^XLEN.
module if_stage_adder
    import if_stage_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: one request in flight, IF/ID pipeline register,
// redirect handling. Optional fetch counter enabled by macro IF_STAGE_PERF_EN.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_WORD
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            ifid_valid_o,
    input  logic            ifid_ready_i,
    output logic [XLEN-1:0] ifid_pc_o,
    output logic [XLEN-1:0] ifid_pc4_o,
    output logic [XLEN-1:0] ifid_instr_o
`ifdef IF_STAGE_PERF_EN
    ,
    output logic [XLEN-1:0] fetch_count_o
`endif
);

    logic [1:0]      state_r;
    logic [1:0]      state_s;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] req_addr_q;
    logic [XLEN-1:0] pc4_s;
    ifid_t           ifid_r;
    logic            issue_s;
    logic            take_s;
    logic            drain_s;

    if_stage_adder u_pc4 (
        .a   (req_addr_q),
        .b   (32'd4),
        .sum (pc4_s)
    );

    // A request may only start when the IF/ID slot is free or draining now;
    // once raised without ack the slot has emptied, so it stays raised.
    assign issue_s = (state_r == ST_FETCH) && (!ifid_r.valid || ifid_ready_i);
    assign take_s  = issue_s && imem_ack_i;
    assign drain_s = ifid_r.valid && ifid_ready_i;

    assign imem_req_o   = !rst && (issue_s || (state_r == ST_DROP));
    assign imem_addr_o  = req_addr_q;
    assign ifid_valid_o = ifid_r.valid;
    assign ifid_pc_o    = ifid_r.pc;
    assign ifid_pc4_o   = ifid_r.pc4;
    assign ifid_instr_o = ifid_r.instr;

    // Fetch FSM next-state logic; redirect outranks ack and stall.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_FETCH: begin
                if (redirect_i) begin
                    state_s = (issue_s && !imem_ack_i) ? ST_DROP : ST_FETCH;
                end else if (take_s) begin
                    state_s = ifid_ready_i ? ST_FETCH : ST_BLOCKED;
                end else if (!issue_s) begin
                    state_s = ST_BLOCKED;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_BLOCKED: begin
                if (redirect_i || drain_s) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_BLOCKED;
                end
            end
            ST_DROP: begin
                if (imem_ack_i) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_DROP;
                end
            end
            default: state_s = ST_FETCH;
        endcase
    end

    // FSM state, next-fetch PC and outstanding request address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_FETCH;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_r <= state_s;
            if (redirect_i) begin
                pc_q <= redirect_pc_i;
            end else if (take_s) begin
                pc_q <= pc4_s;
            end else begin
                pc_q <= pc_q;
            end
            // The stale request in DROP keeps its address until its ack lands.
            if (state_r == ST_DROP) begin
                if (imem_ack_i) begin
                    req_addr_q <= redirect_i ? redirect_pc_i : pc_q;
                end else begin
                    req_addr_q <= req_addr_q;
                end
            end else if (redirect_i) begin
                if (issue_s && !imem_ack_i) begin
                    req_addr_q <= req_addr_q;
                end else begin
                    req_addr_q <= redirect_pc_i;
                end
            end else if (take_s) begin
                req_addr_q <= pc4_s;
            end else begin
                req_addr_q <= req_addr_q;
            end
        end
    end

    // IF/ID register: flush on redirect, refill on ack, NOP when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_r.valid <= 1'b0;
            ifid_r.pc    <= 32'h0000_0000;
            ifid_r.pc4   <= 32'h0000_0000;
            ifid_r.instr <= NOP_INSTR;
        end else if (redirect_i) begin
            ifid_r.valid <= 1'b0;
            ifid_r.instr <= NOP_INSTR;
        end else if (take_s) begin
            ifid_r.valid <= 1'b1;
            ifid_r.pc    <= req_addr_q;
            ifid_r.pc4   <= pc4_s;
            ifid_r.instr <= imem_rdata_i;
        end else if (drain_s) begin
            ifid_r.valid <= 1'b0;
            ifid_r.instr <= NOP_INSTR;
        end else begin
            ifid_r <= ifid_r;
        end
    end

`ifdef IF_STAGE_PERF_EN
    logic [XLEN-1:0] fetch_count_r;

    // Counts instructions accepted by decode; entries flushed by redirect are skipped.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_r <= 32'h0000_0000;
        end else if (drain_s && !redirect_i) begin
            fetch_count_r <= fetch_count_r + 32'd1;
        end else begin
            fetch_count_r <= fetch_count_r;
        end
    end

    assign fetch_count_o = fetch_count_r;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: scoreboard of expected IF/ID entries popped on
// every decode handshake, plus point checks on the fetch interface.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        ifid_valid;
    logic        ifid_ready;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_instr;

    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic        ifid_valid2;
    logic [31:0] ifid_pc2;
    logic [31:0] ifid_pc42;
    logic [31:0] ifid_instr2;

`ifdef IF_STAGE_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] fetch_count2;
`endif

    logic        zero_wait;
    logic        ack_manual;
    logic [31:0] exp_q[$];
    int          total;
    int          passed;
    int          failed;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0003 ^ {a[15:0], 16'h0000};
    endfunction

    assign imem_ack   = zero_wait ? imem_req : ack_manual;
    assign imem_rdata = word_of(imem_addr);

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ack_i    (imem_ack),
        .imem_rdata_i  (imem_rdata),
        .ifid_valid_o  (ifid_valid),
        .ifid_ready_i  (ifid_ready),
        .ifid_pc_o     (ifid_pc),
        .ifid_pc4_o    (ifid_pc4),
        .ifid_instr_o  (ifid_instr)
`ifdef IF_STAGE_PERF_EN
        ,
        .fetch_count_o (fetch_count)
`endif
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk           (clk),
        .rst           (rst),
        .redirect_i    (1'b0),
        .redirect_pc_i (32'h0000_0000),
        .imem_req_o    (imem_req2),
        .imem_addr_o   (imem_addr2),
        .imem_ack_i    (imem_req2),
        .imem_rdata_i  (word_of(imem_addr2)),
        .ifid_valid_o  (ifid_valid2),
        .ifid_ready_i  (1'b1),
        .ifid_pc_o     (ifid_pc2),
        .ifid_pc4_o    (ifid_pc42),
        .ifid_instr_o  (ifid_instr2)
`ifdef IF_STAGE_PERF_EN
        ,
        .fetch_count_o (fetch_count2)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every decode handshake must match the oldest expected PC.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst && ifid_valid && ifid_ready) begin
            check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_pc", ifid_pc, e);
                check("sb_pc4", ifid_pc4, e + 32'd4);
                check("sb_instr", ifid_instr, word_of(e));
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1; ifid_ready = 1'b0; redirect = 1'b0;
        zero_wait = 1'b1; ack_manual = 1'b0;
        next_cycle();
        @(negedge clk);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(ifid_valid), 32'd0);
        check("rst_instr", ifid_instr, 32'h0000_0013);
        check("rst_pc", ifid_pc, 32'h0000_0000);
        check("rst_pc4", ifid_pc4, 32'h0000_0000);
        check("rst_addr", imem_addr, 32'h0000_0000);
        check("rst_addr2", imem_addr2, 32'hFFFF_FFFC);
`ifdef IF_STAGE_PERF_EN
        check("rst_count", fetch_count, 32'd0);
`endif
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        total = 0; passed = 0; failed = 0;
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0000_0000;
        ifid_ready = 1'b0; zero_wait = 1'b1; ack_manual = 1'b0;

        // Back-to-back zero-wait fetch; last request left unacked, then reset.
        do_reset();
        for (int i = 0; i < 5; i++) exp_q.push_back(32'(4 * i));
        ifid_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) zero_wait = 1'b0;
            @(negedge clk);
            check("s1_req", 32'(imem_req), 32'd1);
            check("s1_addr", imem_addr, 32'(4 * k));
            if (k > 0) check("s1_valid", 32'(ifid_valid), 32'd1);
            if (k == 0) check("wrap_addr0", imem_addr2, 32'hFFFF_FFFC);
            if (k == 1) begin
                check("wrap_addr1", imem_addr2, 32'h0000_0000);
                check("wrap_pc", ifid_pc2, 32'hFFFF_FFFC);
                check("wrap_pc4", ifid_pc42, 32'h0000_0000);
            end
            next_cycle();
        end
        check("s1_drained", 32'(exp_q.size()), 32'd0);

        // Stall at PC 8, resume, then redirect with delayed ack.
        do_reset();
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(4 * i));
        ifid_ready = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        ifid_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("s2_req", 32'(imem_req), 32'd0);
            check("s2_valid", 32'(ifid_valid), 32'd1);
            check("s2_pc", ifid_pc, 32'h0000_0008);
            check("s2_instr", ifid_instr, word_of(32'h0000_0008));
            next_cycle();
        end
        ifid_ready = 1'b1;
        @(negedge clk);
        check("s2_blocked_req", 32'(imem_req), 32'd0);
        next_cycle();
        @(negedge clk);
        check("s2_resume_addr", imem_addr, 32'h0000_000C);
        next_cycle();
        zero_wait = 1'b0;
        @(negedge clk);
        check("s3_addr10", imem_addr, 32'h0000_0010);
        next_cycle();
        exp_q.push_back(32'h0000_0100);
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        @(negedge clk);
        check("s3_req_redir", 32'(imem_req), 32'd1);
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        check("s3_drop_req", 32'(imem_req), 32'd1);
        check("s3_drop_addr", imem_addr, 32'h0000_0010);
        check("s3_drop_valid", 32'(ifid_valid), 32'd0);
        next_cycle();
        ack_manual = 1'b1;
        @(negedge clk);
        check("s3_ack_valid", 32'(ifid_valid), 32'd0);
        next_cycle();
        ack_manual = 1'b0; zero_wait = 1'b1;
        @(negedge clk);
        check("s3_target_addr", imem_addr, 32'h0000_0100);
        check("s3_target_valid", 32'(ifid_valid), 32'd0);
        next_cycle();

        // Redirect coincident with the ack of 0x104.
        exp_q.push_back(32'h0000_0200);
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        @(negedge clk);
        check("s4_addr104", imem_addr, 32'h0000_0104);
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        check("s4_gap_valid", 32'(ifid_valid), 32'd0);
        check("s4_target_addr", imem_addr, 32'h0000_0200);
        check("s4_target_req", 32'(imem_req), 32'd1);
        next_cycle();
        zero_wait = 1'b0;
        @(negedge clk);
        check("s4_deliver_pc", ifid_pc, 32'h0000_0200);
        next_cycle();
        @(negedge clk);
        check("s4_after_valid", 32'(ifid_valid), 32'd0);
        check("s4_drained", 32'(exp_q.size()), 32'd0);
        next_cycle();

`ifdef IF_STAGE_PERF_EN
        // Five delivered entries, one flushed while stalled, then reset.
        do_reset();
        for (int i = 0; i < 5; i++) exp_q.push_back(32'(4 * i));
        ifid_ready = 1'b1;
        for (int i = 0; i < 6; i++) next_cycle();
        ifid_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0300;
        @(negedge clk);
        check("perf_five", fetch_count, 32'd5);
        next_cycle();
        redirect = 1'b0; zero_wait = 1'b0;
        @(negedge clk);
        check("perf_flush", fetch_count, 32'd5);
        check("perf_flush_valid", 32'(ifid_valid), 32'd0);
        next_cycle();
        do_reset();
        check("perf_drained", 32'(exp_q.size()), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
